// File: rtl/uart_pkg.sv
// Shared definitions for the serial link (receiver side and transmitter side).
// Parity is even on both ends: the parity bit equals the XOR of the data bits.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    GUARD = 3'd2,
    RESP  = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam int unsigned SIZE_DEFAULT = 32;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx_parity_chk.sv
// Running even-parity accumulator for the receiver. The accumulator is cleared
// on the start bit, folds in each data bit, and the compare output flags a
// mismatch between the accumulated parity and the bit currently on the line.
module uart_rx_parity_chk (
  input  logic CLK_Baudin,
  input  logic RstRx_n,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic mismatch
);

  logic acc;

  // XOR accumulator with synchronous clear
  always_ff @(posedge CLK_Baudin or negedge RstRx_n) begin
    if (!RstRx_n) begin
      acc <= 1'b0;
    end else if (clr) begin
      acc <= 1'b0;
    end else if (en) begin
      acc <= acc ^ bit_in;
    end
  end

  assign mismatch = acc ^ bit_in;

endmodule

// File: rtl/uart_rx.sv
// Serial receiver: start bit, `size` data bits LSB first, even parity, stop.
// A parity error raises Flag_out for two cycles so the transmitter resends;
// good words appear on DataOut with a one-cycle DoneRx pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned size  = SIZE_DEFAULT,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK_Baudin,
  input  logic             RstRx_n,
  input  logic             SerialIn,
  output logic [size-1:0]  DataOut,
  output logic             DoneRx,
  output logic             Flag_out,
  output logic             ParityErr,
  output logic             FrameErr,
  output logic             Busy,
  output logic [CNT_W-1:0] ErrCnt
);

  localparam int unsigned CTR_W = $clog2(size) + 1;
  localparam logic [CTR_W-1:0] PARITY_CNT = CTR_W'(size);

  state_t            state;
  logic [CTR_W-1:0]  bit_cnt;
  logic [size-1:0]   shift_q;
  logic              par_clr;
  logic              par_en;
  logic              par_mismatch;

  // The accumulator clears on the start bit and absorbs data bits only;
  // the parity sample itself is compared, never accumulated.
  assign par_clr = (state == IDLE) && (SerialIn == START_BIT);
  assign par_en  = (state == DATA) && (bit_cnt != PARITY_CNT);

  uart_rx_parity_chk u_parity_chk (
    .CLK_Baudin (CLK_Baudin),
    .RstRx_n    (RstRx_n),
    .clr        (par_clr),
    .en         (par_en),
    .bit_in     (SerialIn),
    .mismatch   (par_mismatch)
  );

  // Frame FSM with registered outputs; pulses default low every cycle
  always_ff @(posedge CLK_Baudin or negedge RstRx_n) begin
    if (!RstRx_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_q   <= '0;
      DataOut   <= '0;
      DoneRx    <= 1'b0;
      Flag_out  <= 1'b0;
      ParityErr <= 1'b0;
      FrameErr  <= 1'b0;
      Busy      <= 1'b0;
      ErrCnt    <= '0;
    end else begin
      DoneRx    <= 1'b0;
      ParityErr <= 1'b0;
      FrameErr  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (SerialIn == START_BIT) begin
            state   <= DATA;
            bit_cnt <= '0;
            Busy    <= 1'b1;
          end
        end
        DATA: begin
          if (bit_cnt == PARITY_CNT) begin
            Flag_out  <= par_mismatch;
            ParityErr <= par_mismatch;
            state     <= GUARD;
          end else begin
            shift_q <= {SerialIn, shift_q[size-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        GUARD: begin
          // Transmitter holds the parity bit one extra cycle; line ignored
          state <= RESP;
        end
        RESP: begin
          // Flag_out still carries this frame's parity result
          if (Flag_out) begin
            Flag_out <= 1'b0;
            if (ErrCnt != '1) ErrCnt <= ErrCnt + 1'b1;
            state    <= IDLE;
            Busy     <= 1'b0;
          end else begin
            state <= STOP;
          end
        end
        STOP: begin
          if (SerialIn == STOP_BIT) begin
            DataOut <= shift_q;
            DoneRx  <= 1'b1;
          end else begin
            FrameErr <= 1'b1;
            if (ErrCnt != '1) ErrCnt <= ErrCnt + 1'b1;
          end
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
